// File: rtl/lc3_pipeline_ctrl_if.sv
// Handshake and control bundle between the LC3 pipeline controller and its datapath.
//   master : controller side. Consumes memory handshakes, instruction words and PSR codes.
//            Drives the stage enables, branch select, memory state and bypass selects.
//   slave  : datapath side, the mirror image of master.
interface lc3_pipeline_ctrl_if;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] Imem_dout;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  psr;

    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        bypass_alu_1;
    logic        bypass_alu_2;

    modport master (
        input  complete_instr, complete_data, Imem_dout, IR, IR_Exec, psr,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, mem_state, bypass_alu_1, bypass_alu_2
    );

    modport slave (
        output complete_instr, complete_data, Imem_dout, IR, IR_Exec, psr,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, mem_state, bypass_alu_1, bypass_alu_2
    );
endinterface

// File: rtl/lc3_pipeline_ctrl.sv
// LC3 pipeline control unit.
// Sequences the fetch/decode/execute/writeback stage enables. This covers pipeline fill,
// Imem wait bubbles, data-memory stalls (READ/INDIRECT/WRITE FSM) and the fixed-length
// control stall after a BR/JMP is fetched.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : lc3_pipeline_ctrl_if.master. Inputs are the memory handshakes, Imem_dout, IR,
//          IR_Exec and psr. Outputs are the stage enables, br_taken, mem_state and the
//          ALU bypass selects.
// Parameters:
//   CTRL_STALL : cycles fetch is frozen after an accepted BR/JMP (>= 2)
// Optional feature:
//   LC3_CTRL_BYPASS_EN : when defined, builds the ALU forwarding compares. Otherwise
//                        bypass_alu_1/2 are tied to 0.
module lc3_pipeline_ctrl #(
    parameter int unsigned CTRL_STALL = 3
) (
    input logic               clk,
    input logic               rst,
    lc3_pipeline_ctrl_if.master bus
);

    localparam int unsigned CntW = $clog2(CTRL_STALL + 1);

    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpLd  = 4'b0010;
    localparam logic [3:0] OpSt  = 4'b0011;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpStr = 4'b0111;
    localparam logic [3:0] OpNot = 4'b1001;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpSti = 4'b1011;
    localparam logic [3:0] OpJmp = 4'b1100;
    localparam logic [3:0] OpLea = 4'b1110;

    typedef enum logic [1:0] {
        StRead     = 2'd0,
        StIndirect = 2'd1,
        StWrite    = 2'd2,
        StIdle     = 2'd3
    } mem_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpNot) || (op == OpLea);
    endfunction

    mem_state_e      mem_state_q, mem_state_d;
    logic            ind_store_q, ind_store_d;   // INDIRECT resolves to WRITE (STI)
    logic            d_v_q, d_v_d;
    logic            e_v_q, e_v_d;
    logic            w_v_q, w_v_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            jmp_q, jmp_d;               // pending control stall is a JMP

    logic [3:0] fetch_op;
    logic [3:0] exec_op;
    logic       mem_busy;
    logic       stall_ctrl;
    logic       fetch_acc;

    assign fetch_op   = bus.Imem_dout[15:12];
    assign exec_op    = bus.IR_Exec[15:12];
    assign mem_busy   = (mem_state_q != StIdle);
    assign stall_ctrl = (cnt_q != '0);
    // Memory stall outranks control stall, which outranks Imem wait.
    assign fetch_acc  = !mem_busy && !stall_ctrl && bus.complete_instr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_state_q <= StIdle;
            ind_store_q <= 1'b0;
            d_v_q       <= 1'b0;
            e_v_q       <= 1'b0;
            w_v_q       <= 1'b0;
            cnt_q       <= '0;
            jmp_q       <= 1'b0;
        end else begin
            mem_state_q <= mem_state_d;
            ind_store_q <= ind_store_d;
            d_v_q       <= d_v_d;
            e_v_q       <= e_v_d;
            w_v_q       <= w_v_d;
            cnt_q       <= cnt_d;
            jmp_q       <= jmp_d;
        end
    end

    // Memory FSM next state
    always_comb begin
        mem_state_d = mem_state_q;
        ind_store_d = ind_store_q;
        unique case (mem_state_q)
            StIdle: begin
                if (e_v_q) begin
                    case (exec_op)
                        OpLd, OpLdr: mem_state_d = StRead;
                        OpSt, OpStr: mem_state_d = StWrite;
                        OpLdi: begin
                            mem_state_d = StIndirect;
                            ind_store_d = 1'b0;
                        end
                        OpSti: begin
                            mem_state_d = StIndirect;
                            ind_store_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StIndirect: begin
                if (bus.complete_data) mem_state_d = ind_store_q ? StWrite : StRead;
            end
            StRead, StWrite: begin
                if (bus.complete_data) mem_state_d = StIdle;
            end
        endcase
    end

    // Valid bits and control-stall counter; everything is frozen during a memory stall.
    always_comb begin
        d_v_d = d_v_q;
        e_v_d = e_v_q;
        w_v_d = w_v_q;
        cnt_d = cnt_q;
        jmp_d = jmp_q;
        if (!mem_busy) begin
            d_v_d = fetch_acc;
            e_v_d = d_v_q;
            w_v_d = e_v_q;
            if (fetch_acc && ((fetch_op == OpBr) || (fetch_op == OpJmp))) begin
                cnt_d = CntW'(CTRL_STALL);
                jmp_d = (fetch_op == OpJmp);
            end else if (stall_ctrl) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    // Outputs
    logic       upd_pc, fetch_en, decode_en, execute_en, wb_en, br;
    logic [1:0] mem_state_out;

    always_comb begin
        upd_pc        = 1'b0;
        fetch_en      = 1'b0;
        decode_en     = 1'b0;
        execute_en    = 1'b0;
        wb_en         = 1'b0;
        br            = 1'b0;
        mem_state_out = StIdle;
        if (!rst) begin
            mem_state_out = mem_state_q;
            if (mem_busy) begin
                // Only a completing load result is written back.
                wb_en = (mem_state_q == StRead) && bus.complete_data;
            end else begin
                fetch_en   = !stall_ctrl;
                // Last stall cycle loads the redirect (or fall-through) PC.
                upd_pc     = stall_ctrl ? (cnt_q == CntW'(1)) : bus.complete_instr;
                decode_en  = d_v_q;
                execute_en = e_v_q;
                wb_en      = w_v_q && is_alu_op(exec_op);
                br         = (cnt_q == CntW'(1)) && (jmp_q || |(bus.IR_Exec[11:9] & bus.psr));
            end
        end
    end

    assign bus.enable_updatePC  = upd_pc;
    assign bus.enable_fetch     = fetch_en;
    assign bus.enable_decode    = decode_en;
    assign bus.enable_execute   = execute_en;
    assign bus.enable_writeback = wb_en;
    assign bus.br_taken         = br;
    assign bus.mem_state        = mem_state_out;

`ifdef LC3_CTRL_BYPASS_EN
    logic [3:0] ir_op;
    logic       byp_1, byp_2;

    assign ir_op = bus.IR[15:12];

    always_comb begin
        byp_1 = 1'b0;
        byp_2 = 1'b0;
        if (!rst && !mem_busy && e_v_q && is_alu_op(exec_op)) begin
            byp_1 = (bus.IR_Exec[11:9] == bus.IR[8:6]) &&
                    (is_alu_op(ir_op) || (ir_op == OpLdr) || (ir_op == OpStr) ||
                     (ir_op == OpJmp));
            byp_2 = (bus.IR_Exec[11:9] == bus.IR[2:0]) &&
                    ((ir_op == OpAdd) || (ir_op == OpAnd)) && !bus.IR[5];
        end
    end

    assign bus.bypass_alu_1 = byp_1;
    assign bus.bypass_alu_2 = byp_2;
`else
    assign bus.bypass_alu_1 = 1'b0;
    assign bus.bypass_alu_2 = 1'b0;
`endif

    // Instruction fields this controller does not decode.
    logic unused_bits;
    assign unused_bits = ^{bus.Imem_dout[11:0], bus.IR, bus.IR_Exec[8:0]};

endmodule
